// File: rtl/adder10_seq.sv
// adder10_seq: sequential 10-bit adder that time-multiplexes one 5-bit ripple
// adder (Adder5) over two cycles, low half first, then high half.
//
// Ports:
//   Clk    in   rising-edge clock
//   Reset  in   asynchronous active-high reset
//   Start  in   request a new add (accepted in IDLE or DONE)
//   A, B   in   10-bit operands, captured on Start acceptance
//   Cin    in   carry-in, captured on Start acceptance
//   Busy   out  high in LOW and HIGH
//   Done   out  one-cycle pulse when Sum/Cout hold the new result
//   Sum    out  registered 10-bit result
//   Cout   out  registered carry out of bit 9
//   Ovf    out  registered two's-complement overflow
//               (only when ADDER10_SIGNED_OVF_EN is defined)
//
// Parameter CLEAR_ON_START: 1 clears Sum/Cout(/Ovf) when a Start is accepted,
// 0 holds the previous result until it is overwritten.
// Optional feature macro: ADDER10_SIGNED_OVF_EN.

module adder10_seq #(
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] A,
    input  logic [9:0] B,
    input  logic       Cin,
    output logic       Busy,
    output logic       Done,
    output logic [9:0] Sum,
`ifdef ADDER10_SIGNED_OVF_EN
    output logic       Cout,
    output logic       Ovf
`else
    output logic       Cout
`endif
);

    localparam int unsigned W  = 10;
    localparam int unsigned HW = 5;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            accept;
`ifdef ADDER10_SIGNED_OVF_EN
    logic            ovf_q, ovf_d;
    logic            c9;
`endif

    logic [HW-1:0]   add_a, add_b, add_s;
    logic            add_ci, add_co;

    // Adder operand mux: high half in HIGH, low half otherwise.
    always_comb begin
        add_a  = a_q[HW-1:0];
        add_b  = b_q[HW-1:0];
        add_ci = cin_q;
        if (state_q == HIGH) begin
            add_a  = a_q[W-1:HW];
            add_b  = b_q[W-1:HW];
            add_ci = carry_q;
        end
    end

    Adder5 u_adder5 (
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_ci),
        .Sum  (add_s),
        .Cout (add_co)
    );

`ifdef ADDER10_SIGNED_OVF_EN
    // Carry into bit 9 recovered from the bit-9 sum: c9 = a9 ^ b9 ^ s9.
    assign c9 = a_q[W-1] ^ b_q[W-1] ^ add_s[HW-1];
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        accept  = 1'b0;
`ifdef ADDER10_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                sum_d[HW-1:0] = add_s;
                carry_d       = add_co;
                state_d       = HIGH;
            end
            HIGH: begin
                sum_d[W-1:HW] = add_s;
                cout_d        = add_co;
`ifdef ADDER10_SIGNED_OVF_EN
                ovf_d         = c9 ^ add_co;
`endif
                state_d       = DONE;
            end
            DONE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d   = A;
            b_d   = B;
            cin_d = Cin;
            if (CLEAR_ON_START) begin
                sum_d  = '0;
                cout_d = 1'b0;
`ifdef ADDER10_SIGNED_OVF_EN
                ovf_d  = 1'b0;
`endif
            end
        end

        busy_d = (state_d == LOW) || (state_d == HIGH);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDER10_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADDER10_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef ADDER10_SIGNED_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// Adder5: 5-bit ripple-carry adder.
//   A, B in 5-bit operands; Cin in carry-in; Sum out 5-bit sum; Cout out carry.
module Adder5 (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Cin,
    output logic [4:0] Sum,
    output logic       Cout
);

    logic [5:0] c;

    // Full-adder chain.
    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 5; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[5];
    end

endmodule

// File: tb/tb_adder10_seq.sv
// tb_adder10_seq: directed self-checking bench for adder10_seq
// (default parameters; Ovf checks when ADDER10_SIGNED_OVF_EN is defined).

module tb_adder10_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [9:0] sum;
    logic       cout;
`ifdef ADDER10_SIGNED_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    adder10_seq dut (
        .Clk   (clk),
        .Reset (rst),
        .Start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Busy  (busy),
        .Done  (done),
        .Sum   (sum),
`ifdef ADDER10_SIGNED_OVF_EN
        .Cout  (cout),
        .Ovf   (ovf)
`else
        .Cout  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse Start for one edge and return the number of negedges until Done (bounded).
    task automatic do_add(input logic [9:0] av, input logic [9:0] bv, input logic cv,
                          output int lat);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, sum, cout} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_carry_prop;
        int lat;
        do_add(10'h01F, 10'h001, 1'b0, lat);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL carry_latency: got %0d, want 3", lat);
        end
        total++;
        if (sum !== 10'h020 || cout !== 1'b0) begin
            bad++;
            $display("FAIL carry_prop: got sum=%h cout=%b, want 020/0", sum, cout);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_in_done: got %b, want 0", busy);
        end
    endtask

    task automatic test_wrap;
        int lat;
        @(negedge clk);
        do_add(10'h3FF, 10'h001, 1'b0, lat);
        total++;
        if (lat !== 3 || sum !== 10'h000 || cout !== 1'b1) begin
            bad++;
            $display("FAIL wrap_3ff_1: got lat=%0d sum=%h cout=%b, want 3/000/1", lat, sum, cout);
        end
        @(negedge clk);
        do_add(10'h3FF, 10'h3FF, 1'b1, lat);
        total++;
        if (lat !== 3 || sum !== 10'h3FF || cout !== 1'b1) begin
            bad++;
            $display("FAIL wrap_max: got lat=%0d sum=%h cout=%b, want 3/3ff/1", lat, sum, cout);
        end
        // Result must hold across idle cycles.
        repeat (4) @(negedge clk);
        total++;
        if (sum !== 10'h3FF || cout !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got sum=%h cout=%b done=%b, want 3ff/1/0", sum, cout, done);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        start = 1'b1; a = 10'd5; b = 10'd7; cin = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            exp_done = (n == 3) || (n == 6);
            total++;
            if (done !== exp_done || (busy & done) !== 1'b0) begin
                bad++;
                $display("FAIL b2b_handshake n=%0d: got done=%b busy=%b, want done=%b", n, done, busy, exp_done);
            end
            if (n == 3) begin
                total++;
                if (sum !== 10'd12) begin
                    bad++;
                    $display("FAIL b2b_first: got sum=%0d, want 12", sum);
                end
                a = 10'd100; b = 10'd28;
            end
            if (n == 6) begin
                total++;
                if (sum !== 10'd128 || cout !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_second: got sum=%0d cout=%b, want 128/0", sum, cout);
                end
                start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        start = 1'b1; a = 10'h010; b = 10'h020; cin = 1'b0;
        @(negedge clk);
        // LOW cycle: new request with different operands must be ignored.
        a = 10'h155; b = 10'h0AA; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_high: got %b, want 1", busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || sum !== 10'h030 || cout !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start: got done=%b sum=%h cout=%b, want 1/030/0", done, sum, cout);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL no_extra_done n=%0d: got done=%b busy=%b, want 0/0", n, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start = 1'b1; a = 10'h01F; b = 10'h001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, sum, cout} !== 13'h0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle n=%0d: got done=%b busy=%b, want 0/0", n, done, busy);
            end
        end
        do_add(10'h123, 10'h0DD, 1'b1, lat);
        total++;
        if (lat !== 3 || sum !== 10'h201 || cout !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_add: got lat=%0d sum=%h cout=%b, want 3/201/0", lat, sum, cout);
        end
        @(negedge clk);
    endtask

`ifdef ADDER10_SIGNED_OVF_EN
    task automatic test_ovf;
        int lat;
        do_add(10'h1FF, 10'h001, 1'b0, lat);
        total++;
        if (lat !== 3 || sum !== 10'h200 || ovf !== 1'b1 || cout !== 1'b0) begin
            bad++;
            $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b, want 200/1/0", sum, ovf, cout);
        end
        @(negedge clk);
        do_add(10'h200, 10'h3FF, 1'b0, lat);
        total++;
        if (lat !== 3 || sum !== 10'h1FF || ovf !== 1'b1 || cout !== 1'b1) begin
            bad++;
            $display("FAIL ovf_neg: got sum=%h ovf=%b cout=%b, want 1ff/1/1", sum, ovf, cout);
        end
        @(negedge clk);
        do_add(10'h3FF, 10'h001, 1'b0, lat);
        total++;
        if (lat !== 3 || sum !== 10'h000 || ovf !== 1'b0 || cout !== 1'b1) begin
            bad++;
            $display("FAIL ovf_none: got sum=%h ovf=%b cout=%b, want 000/0/1", sum, ovf, cout);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_carry_prop();
        test_wrap();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
`ifdef ADDER10_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder10_seq.md
Name: adder10_seq

Overview:
- Sequential 10-bit adder built from one `Adder5` instance, the team's 5-bit ripple adder.
- The single `Adder5` is time-multiplexed over two cycles: first the low half (bits 4:0), then the high half (bits 9:5).
- The low-half carry is held in a register between the two cycles.
- Sits directly upstream of `Adder5`: it stages the operands, sequences the two passes, and collects the sum and carry into a result register.
- Uses a Start/Busy/Done handshake, so a datapath controller can issue 10-bit adds without a second adder instance.

Parameters:
- CLEAR_ON_START, 0: when 1, Sum, Cout (and Ovf if enabled) clear to 0 in the cycle a Start is accepted. When 0, they hold the previous result until the new result is written.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request a new add; sampled on the rising edge of Clk
- A  input  10  operand A; captured when Start is accepted
- B  input  10  operand B; captured when Start is accepted
- Cin  input  1  carry-in; captured when Start is accepted
- Busy  output  1  high while an add is in progress (states LOW, HIGH)
- Done  output  1  one-cycle pulse; the result is valid on Sum/Cout
- Sum  output  10  registered result
- Cout  output  1  registered carry-out of bit 9

Behaviour:
- Reset (asynchronous, active-high):
  - state is IDLE
  - Busy=0, Done=0, Sum=0, Cout=0
  - operand registers and the low-half carry register are 0
  - Reset asserted mid-operation aborts the add immediately; no Done is produced.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - if Start=1 at a Clk edge, capture A, B, Cin into operand registers and go to LOW.
  - if Start=0, stay in IDLE.
- LOW:
  - `Adder5` inputs are Aq[4:0], Bq[4:0], Cq.
  - at the next edge: Sum[4:0] ← adder sum, carry register ← adder Cout; go to HIGH.
- HIGH:
  - `Adder5` inputs are Aq[9:5], Bq[9:5], carry register.
  - at the next edge: Sum[9:5] ← adder sum, Cout ← adder Cout; go to DONE.
- DONE:
  - Done=1 for exactly one cycle.
  - if Start=1 at this edge, capture the new operands and go to LOW (back-to-back add, no idle bubble).
  - otherwise go to IDLE.
- Busy=1 exactly in LOW and HIGH. Done=1 exactly in DONE. Done and Busy are never high together.
- Latency: Start sampled at edge k → Done high in the cycle after edge k+2. Throughput is one add per 3 cycles.
- Start while Busy=1 is ignored; the in-flight operands are unaffected.
- Operand capture:
  - A/B/Cin are sampled only on Start acceptance.
  - changes on A/B/Cin during LOW/HIGH have no effect on the result.
- Sum[4:0] updates at the end of LOW. Consumers must read Sum/Cout only when Done=1; intermediate values are undefined to the consumer.
- Output holding:
  - with CLEAR_ON_START=0, Sum/Cout hold their last value until overwritten, including across IDLE periods.
  - with CLEAR_ON_START=1, they read 0 from the edge after Start acceptance until written.
- Arithmetic is unsigned modulo 2^10. Cout is the true bit 10 of A+B+Cin.

Optional Feature:
- Macro: ADDER10_SIGNED_OVF_EN
- When defined, adds output port Ovf (1 bit, registered):
  - written at the end of HIGH as the carry into bit 9 XOR the carry out of bit 9 (two's-complement overflow).
  - reset to 0.
  - follows the same hold/clear rules as Cout.
- The carry into bit 9 is obtained by adding bits 8:5 separately or by recomputing bit 9 (A9^B9^S9). Either is acceptable if the result is exact.
- When undefined, the port Ovf does not exist and the logic is absent.

Test Plan:
- A=0x01F, B=0x001, Cin=0, Start pulse → Done 3 cycles later (the cycle after edge k+2); Sum=0x020, Cout=0. Checks that the low-half carry propagates into the high half.
- A=0x3FF, B=0x001, Cin=0 → Sum=0x000, Cout=1. Then A=0x3FF, B=0x3FF, Cin=1 → Sum=0x3FF, Cout=1.
- Hold Start=1 continuously with A=5, B=7, then A=100, B=28 (change applied in the DONE cycle) → Done pulses every 3 cycles; first Sum=12, then Sum=128; Busy never high while Done=1.
- Start accepted, then Start=1 with A=0x155, B=0x0AA in the LOW cycle → second request ignored; original result appears; no extra Done.
- Assert Reset during HIGH → Busy, Done, Sum, Cout go to 0 immediately (asynchronous); no Done after release; the next Start works normally.
- With ADDER10_SIGNED_OVF_EN: A=0x1FF, B=0x001 → Sum=0x200, Ovf=1, Cout=0. Then A=0x200, B=0x3FF → Sum=0x1FF, Ovf=1, Cout=1.
